div16: RTL and testbench

DIV16 -- requirements
Module: div16

---
 rtl/div16.sv | 142 ++++++++++++++
 tb/tb_div16.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div16.sv
// Radix-2 restoring divider for 16-bit unsigned or two's complement operands.
// One trial subtract per CALC cycle; divide-by-zero and signed overflow skip CALC.
module div16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        mode,
   output logic [15:0] Q,
   output logic [15:0] R,
   output logic        busy,
   output logic        done,
   output logic        DZ,
   output logic        V
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      r_state;
   state_t      w_next;

   logic [15:0] r_rem;
   logic [15:0] r_dvd;
   logic [15:0] r_dvs;
   logic [15:0] r_aRaw;
   logic [3:0]  r_count;
   logic        r_qNeg;
   logic        r_rNeg;
   logic        r_dz;
   logic        r_ovf;
   logic [15:0] r_q;
   logic [15:0] r_r;
   logic        r_DZ;
   logic        r_V;

   logic        w_accept;
   logic        w_bZero;
   logic        w_ovf;
   logic [15:0] w_aMag;
   logic [15:0] w_bMag;
   logic [16:0] w_shift;
   logic [16:0] w_diff;
   logic        w_fits;

   assign w_accept = (r_state == IDLE) && start;
   assign w_bZero  = (B == 16'h0000);
   assign w_ovf    = mode && (A == 16'h8000) && (B == 16'hFFFF);
   assign w_aMag   = (mode && A[15]) ? (~A + 16'd1) : A;
   assign w_bMag   = (mode && B[15]) ? (~B + 16'd1) : B;

   // The partial remainder is always below the divisor, so after the shift it
   // needs one extra bit; the carry-out of A + ~B + 1 is folded into bit 16.
   assign w_shift  = {r_rem, r_dvd[15]};
   assign w_diff   = w_shift + {1'b1, ~r_dvs} + 17'd1;
   assign w_fits   = ~w_diff[16];

   assign busy = (r_state == CALC) || (r_state == FIX);
   assign done = (r_state == DONE);
   assign Q    = r_q;
   assign R    = r_r;
   assign DZ   = r_DZ;
   assign V    = r_V;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = (w_bZero || w_ovf) ? FIX : CALC;
            end
         end
         CALC: begin
            if (r_count == 4'd15) begin
               w_next = FIX;
            end
         end
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem   <= 16'h0000;
         r_dvd   <= 16'h0000;
         r_dvs   <= 16'h0000;
         r_aRaw  <= 16'h0000;
         r_count <= 4'd0;
         r_qNeg  <= 1'b0;
         r_rNeg  <= 1'b0;
         r_dz    <= 1'b0;
         r_ovf   <= 1'b0;
         r_q     <= 16'h0000;
         r_r     <= 16'h0000;
         r_DZ    <= 1'b0;
         r_V     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rem   <= 16'h0000;
            r_dvd   <= w_aMag;
            r_dvs   <= w_bMag;
            r_aRaw  <= A;
            r_count <= 4'd0;
            r_qNeg  <= mode && (A[15] ^ B[15]);
            r_rNeg  <= mode && A[15];
            r_dz    <= w_bZero;
            r_ovf   <= w_ovf && !w_bZero;
            r_DZ    <= 1'b0;
            r_V     <= 1'b0;
         end else if (r_state == CALC) begin
            r_rem   <= w_fits ? w_diff[15:0] : w_shift[15:0];
            r_dvd   <= {r_dvd[14:0], w_fits};
            r_count <= r_count + 4'd1;
         end else if (r_state == FIX) begin
            // The dividend register has been fully replaced by quotient bits.
            if (r_dz) begin
               r_q  <= 16'hFFFF;
               r_r  <= r_aRaw;
               r_DZ <= 1'b1;
            end else if (r_ovf) begin
               r_q  <= 16'h8000;
               r_r  <= 16'h0000;
               r_V  <= 1'b1;
            end else begin
               r_q  <= r_qNeg ? (~r_dvd + 16'd1) : r_dvd;
               r_r  <= r_rNeg ? (~r_rem + 16'd1) : r_rem;
            end
         end
      end
   end

endmodule

// File: tb/tb_div16.sv
// Scoreboard bench for div16: stimulus pushes expected results, a monitor
// pops and compares them whenever done is seen.
module tb_div16;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        mode;
   logic [15:0] Q;
   logic [15:0] R;
   logic        busy;
   logic        done;
   logic        DZ;
   logic        V;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        v;
      int          doneEdge;
   } expect_t;

   expect_t sbQueue[$];
   int      checks = 0;
   int      errors = 0;
   int      edgeCnt = 0;

   div16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .mode  (mode),
      .Q     (Q),
      .R     (R),
      .busy  (busy),
      .done  (done),
      .DZ    (DZ),
      .V     (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbQueue.size() == 0) begin
            checkOutput("unexpected done", 32'd1, 32'd0);
         end else begin
            expect_t e;
            e = sbQueue.pop_front();
            checkOutput("Q", Q, e.q);
            checkOutput("R", R, e.r);
            checkOutput("DZ", DZ, e.dz);
            checkOutput("V", V, e.v);
            checkOutput("done edge", edgeCnt, e.doneEdge);
            checkOutput("busy at done", busy, 1'b0);
         end
      end
   end

   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while ((busy || done) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) checkOutput("idle timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sbQueue.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sbQueue.size() != 0) begin
         checkOutput("done timeout", sbQueue.size(), 32'd0);
         sbQueue.delete();
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic m,
                                input logic [15:0] eq, input logic [15:0] er,
                                input logic edz, input logic ev, input int lat, input bit push);
      expect_t e;
      waitIdle();
      A     = a;
      B     = b;
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.q        = eq;
         e.r        = er;
         e.dz       = edz;
         e.v        = ev;
         e.doneEdge = edgeCnt + lat;
         sbQueue.push_back(e);
      end
      checkOutput("busy after accept", busy, 1'b1);
      checkOutput("DZ cleared at accept", DZ, 1'b0);
      checkOutput("V cleared at accept", V, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A     = 16'h0000;
      B     = 16'h0000;
      mode  = 1'b0;
      #1;
      checkOutput("reset Q", Q, 16'h0000);
      checkOutput("reset R", R, 16'h0000);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset DZ", DZ, 1'b0);
      checkOutput("reset V", V, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Unsigned 100/7 with busy window t0..t16 and done at t17.
      applyStimulus(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0, 17, 1'b1);
      repeat (16) @(posedge clk);
      #1;
      checkOutput("busy after t16", busy, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("busy after t17", busy, 1'b0);
      drain();

      // Signed: -7/2 and 7/-2.
      applyStimulus(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 1'b1);
      drain();
      applyStimulus(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17, 1'b1);
      drain();

      // Divide by zero in both modes, then hold of flags and results.
      applyStimulus(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1, 1'b1);
      drain();
      applyStimulus(16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1, 1'b1);
      drain();
      repeat (3) @(negedge clk);
      checkOutput("DZ held", DZ, 1'b1);
      checkOutput("Q held", Q, 16'hFFFF);
      checkOutput("R held", R, 16'h1234);

      // Signed overflow, then the same bits as unsigned (32768/65535 = 0 rem 32768).
      applyStimulus(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1, 1'b1);
      drain();
      applyStimulus(16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 17, 1'b1);
      drain();

      // Inputs scrambled and start re-pulsed while busy; start held through done cycle.
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 1'b1);
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         A     = 16'h1357 + 16'(i * 16'h0101);
         B     = 16'(i);
         mode  = i[0];
         start = i[1];
      end
      begin
         int n = 0;
         @(negedge clk);
         start = 1'b1;
         while (!done && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) checkOutput("scramble done timeout", 32'd1, 32'd0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("start in done ignored", busy, 1'b0);
      checkOutput("queue empty after scramble", sbQueue.size(), 32'd0);

      // Reset between t7 and t8 aborts the division.
      applyStimulus(16'd100, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 17, 1'b0);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort Q", Q, 16'h0000);
      checkOutput("abort R", R, 16'h0000);
      checkOutput("abort busy", busy, 1'b0);
      checkOutput("abort done", done, 1'b0);
      checkOutput("abort DZ", DZ, 1'b0);
      checkOutput("abort V", V, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("no done after abort", done, 1'b0);
      applyStimulus(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, 1'b0, 17, 1'b1);
      drain();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
